dm_cache_ctrl: RTL and testbench

- Direct-mapped, write-through, no-write-allocate cache controller.
- Sits directly downstream of the processor's memory port and upstream of main memory.
- Speaks the same level-request / one-cycle-ack protocol on both sides (`IDEL/`RD/`WT from def.v), so the cache is transparent to the CPU.
- Serves read hits locally with 1-cycle latency and forwards misses and all writes to memory.

---
 rtl/dm_cache_ctrl.sv | 167 ++++++++++++++++
 tb/tb_dm_cache_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller placed between
// the CPU memory port and main memory; both sides use the level-request / one-cycle-ack protocol.
module dm_cache_ctrl #(
  parameter int WORDWIDTH    = 8,
  parameter int ADDRWIDTH    = 8,
  parameter int INDEXWIDTH   = 2,
  parameter int CNTWIDTH     = 8,
  parameter int IOSTATEWIDTH = 2,
  parameter logic [IOSTATEWIDTH-1:0] IDEL = IOSTATEWIDTH'(0),
  parameter logic [IOSTATEWIDTH-1:0] RD   = IOSTATEWIDTH'(1),
  parameter logic [IOSTATEWIDTH-1:0] WT   = IOSTATEWIDTH'(2)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [IOSTATEWIDTH-1:0] rwFromCpu,
  input  logic [ADDRWIDTH-1:0]    addrFromCpu,
  input  logic [WORDWIDTH-1:0]    dataFromCpu,
  output logic                    rdEn,
  output logic                    wtEn,
  output logic [WORDWIDTH-1:0]    dataToCpu,
  output logic [IOSTATEWIDTH-1:0] rwToMem,
  output logic [ADDRWIDTH-1:0]    addrToMem,
  output logic [WORDWIDTH-1:0]    dataToMem,
  input  logic                    rdEnFromMem,
  input  logic                    wtEnFromMem,
  input  logic [WORDWIDTH-1:0]    dataFromMem,
  output logic [CNTWIDTH-1:0]     hitCount,
  output logic [CNTWIDTH-1:0]     missCount,
  output logic [2:0]              ctrlState
);

  localparam int LINES    = 1 << INDEXWIDTH;
  localparam int TAGWIDTH = ADDRWIDTH - INDEXWIDTH;
  localparam logic [CNTWIDTH-1:0] CNT_MAX = {CNTWIDTH{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_WRITE = 3'd2,
    S_ACK   = 3'd3
  } state_t;

  state_t state_reg;

  logic [LINES-1:0]     line_valid;
  logic [TAGWIDTH-1:0]  line_tag  [LINES];
  logic [WORDWIDTH-1:0] line_data [LINES];

  logic [INDEXWIDTH-1:0] cpu_idx;
  logic [TAGWIDTH-1:0]   cpu_tag;
  logic [INDEXWIDTH-1:0] mem_idx;
  logic [TAGWIDTH-1:0]   mem_tag;
  logic                  cpu_hit;
  logic                  mem_hit;
  logic                  fill_we;
  logic                  upd_we;

  assign cpu_idx = addrFromCpu[INDEXWIDTH-1:0];
  assign cpu_tag = addrFromCpu[ADDRWIDTH-1:INDEXWIDTH];
  // Once a miss or write is issued, the latched memory address names the line.
  assign mem_idx = addrToMem[INDEXWIDTH-1:0];
  assign mem_tag = addrToMem[ADDRWIDTH-1:INDEXWIDTH];

  assign cpu_hit = line_valid[cpu_idx] && (line_tag[cpu_idx] == cpu_tag);
  assign mem_hit = line_valid[mem_idx] && (line_tag[mem_idx] == mem_tag);

  assign fill_we = (state_reg == S_FILL)  && rdEnFromMem;
  assign upd_we  = (state_reg == S_WRITE) && wtEnFromMem && mem_hit;

  genvar gi;
  generate
    for (gi = 0; gi < LINES; gi++) begin : g_line
      logic                 valid_reg;
      logic [TAGWIDTH-1:0]  tag_reg;
      logic [WORDWIDTH-1:0] data_reg;
      logic                 sel;

      assign sel = (mem_idx == INDEXWIDTH'(gi));

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          valid_reg <= 1'b0;
        end else if (fill_we && sel) begin
          valid_reg <= 1'b1;
        end
      end

      // Tag/data need no reset: they are never consulted while the valid bit is clear.
      always_ff @(posedge clk) begin
        if (fill_we && sel) begin
          tag_reg  <= mem_tag;
          data_reg <= dataFromMem;
        end else if (upd_we && sel) begin
          data_reg <= dataToMem;
        end
      end

      assign line_valid[gi] = valid_reg;
      assign line_tag[gi]   = tag_reg;
      assign line_data[gi]  = data_reg;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= S_IDLE;
      rdEn      <= 1'b0;
      wtEn      <= 1'b0;
      dataToCpu <= '0;
      rwToMem   <= IDEL;
      addrToMem <= '0;
      dataToMem <= '0;
      hitCount  <= '0;
      missCount <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (rwFromCpu == RD) begin
            if (cpu_hit) begin
              dataToCpu <= line_data[cpu_idx];
              rdEn      <= 1'b1;
              if (hitCount != CNT_MAX) hitCount <= hitCount + CNTWIDTH'(1);
              state_reg <= S_ACK;
            end else begin
              rwToMem   <= RD;
              addrToMem <= addrFromCpu;
              if (missCount != CNT_MAX) missCount <= missCount + CNTWIDTH'(1);
              state_reg <= S_FILL;
            end
          end else if (rwFromCpu == WT) begin
            rwToMem   <= WT;
            addrToMem <= addrFromCpu;
            dataToMem <= dataFromCpu;
            state_reg <= S_WRITE;
          end
        end
        S_FILL: begin
          if (rdEnFromMem) begin
            dataToCpu <= dataFromMem;
            rdEn      <= 1'b1;
            rwToMem   <= IDEL;
            state_reg <= S_ACK;
          end
        end
        S_WRITE: begin
          if (wtEnFromMem) begin
            wtEn      <= 1'b1;
            rwToMem   <= IDEL;
            state_reg <= S_ACK;
          end
        end
        S_ACK: begin
          rdEn <= 1'b0;
          wtEn <= 1'b0;
          // A request still held after its ack is stale; wait for the CPU to drop it.
          if (rwFromCpu == IDEL) state_reg <= S_IDLE;
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign ctrlState = state_reg;

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Directed bench for dm_cache_ctrl: a vector table of CPU transactions with a scripted
// memory responder, plus hand sequences for async reset, stray codes/acks and saturation.
module tb_dm_cache_ctrl;

  localparam logic [1:0] C_IDEL = 2'd0;
  localparam logic [1:0] C_RD   = 2'd1;
  localparam logic [1:0] C_WT   = 2'd2;

  logic       clk;
  logic       reset;
  logic [1:0] rwFromCpu;
  logic [7:0] addrFromCpu;
  logic [7:0] dataFromCpu;
  logic       rdEn;
  logic       wtEn;
  logic [7:0] dataToCpu;
  logic [1:0] rwToMem;
  logic [7:0] addrToMem;
  logic [7:0] dataToMem;
  logic       rdEnFromMem;
  logic       wtEnFromMem;
  logic [7:0] dataFromMem;
  logic [7:0] hitCount;
  logic [7:0] missCount;
  logic [2:0] ctrlState;

  int n_cmp  = 0;
  int n_fail = 0;

  dm_cache_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .rwFromCpu   (rwFromCpu),
    .addrFromCpu (addrFromCpu),
    .dataFromCpu (dataFromCpu),
    .rdEn        (rdEn),
    .wtEn        (wtEn),
    .dataToCpu   (dataToCpu),
    .rwToMem     (rwToMem),
    .addrToMem   (addrToMem),
    .dataToMem   (dataToMem),
    .rdEnFromMem (rdEnFromMem),
    .wtEnFromMem (wtEnFromMem),
    .dataFromMem (dataFromMem),
    .hitCount    (hitCount),
    .missCount   (missCount),
    .ctrlState   (ctrlState)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] rw;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         delay;     // memory ack on this many cycles of visible request
    logic [7:0] mdata;
    int         hold;      // extra cycles the CPU holds its request after the ack
    int         exp_ack;   // cycle (after the drive) at which rdEn/wtEn is seen
    int         exp_req;   // cycles rwToMem is non-idle
    logic [7:0] exp_data;
    int         exp_hit;
    int         exp_miss;
  } txn_t;

  txn_t tbl[10];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic run_txn(input int id, input txn_t t);
    int ack_cyc = 0;
    int pulses  = 0;
    int req_cyc = 0;
    int req_ok  = 1;
    logic [7:0] data_at_ack = 8'h00;
    @(negedge clk);
    rwFromCpu   = t.rw;
    addrFromCpu = t.addr;
    dataFromCpu = t.wdata;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      rdEnFromMem = 1'b0;
      wtEnFromMem = 1'b0;
      if (rdEn || wtEn) begin
        pulses++;
        if (ack_cyc == 0) begin
          ack_cyc     = cyc;
          data_at_ack = dataToCpu;
        end
      end
      if (rwToMem != C_IDEL) begin
        req_cyc++;
        if (rwToMem != t.rw || addrToMem != t.addr || (t.rw == C_WT && dataToMem != t.wdata))
          req_ok = 0;
        if (req_cyc == t.delay) begin
          if (rwToMem == C_RD) begin
            rdEnFromMem = 1'b1;
            dataFromMem = t.mdata;
          end else begin
            wtEnFromMem = 1'b1;
          end
        end
      end
      if (ack_cyc != 0 && cyc == ack_cyc + t.hold) rwFromCpu = C_IDEL;
      if (ack_cyc != 0 && cyc >= ack_cyc + t.hold + 2) break;
    end
    rwFromCpu = C_IDEL;
    $display("txn %0d rw=%0d addr=%02h ack_cyc=%0d pulses=%0d req_cyc=%0d data=%02h hits=%0d misses=%0d",
             id, t.rw, t.addr, ack_cyc, pulses, req_cyc, data_at_ack, hitCount, missCount);
    chk($sformatf("txn%0d_ack_cycle", id), ack_cyc, t.exp_ack);
    chk($sformatf("txn%0d_ack_pulses", id), pulses, 1);
    chk($sformatf("txn%0d_mem_req_cycles", id), req_cyc, t.exp_req);
    chk($sformatf("txn%0d_mem_req_fields", id), req_ok, 1);
    if (t.rw == C_RD) chk($sformatf("txn%0d_read_data", id), data_at_ack, t.exp_data);
    chk($sformatf("txn%0d_hitCount", id), hitCount, t.exp_hit);
    chk($sformatf("txn%0d_missCount", id), missCount, t.exp_miss);
    chk($sformatf("txn%0d_end_state", id), ctrlState, 0);
  endtask

  initial begin
    txn_t t;
    //            rw    addr   wdata  dly mdata  hold ack req data   hit miss
    tbl[0] = '{C_RD, 8'h05, 8'h00, 3, 8'h3C, 0, 4, 3, 8'h3C, 0, 1};
    tbl[1] = '{C_RD, 8'h05, 8'h00, 0, 8'h00, 0, 1, 0, 8'h3C, 1, 1};
    tbl[2] = '{C_WT, 8'h05, 8'h77, 2, 8'h00, 0, 3, 2, 8'h00, 1, 1};
    tbl[3] = '{C_RD, 8'h05, 8'h00, 0, 8'h00, 0, 1, 0, 8'h77, 2, 1};
    tbl[4] = '{C_RD, 8'h09, 8'h00, 1, 8'h11, 0, 2, 1, 8'h11, 2, 2};
    tbl[5] = '{C_RD, 8'h05, 8'h00, 2, 8'h77, 0, 3, 2, 8'h77, 2, 3};
    tbl[6] = '{C_RD, 8'h05, 8'h00, 0, 8'h00, 3, 1, 0, 8'h77, 3, 3};
    tbl[7] = '{C_WT, 8'h0A, 8'h55, 1, 8'h00, 0, 2, 1, 8'h00, 3, 3};
    tbl[8] = '{C_RD, 8'h0A, 8'h00, 2, 8'h66, 0, 3, 2, 8'h66, 3, 4};
    tbl[9] = '{C_RD, 8'h09, 8'h00, 1, 8'h11, 0, 2, 1, 8'h11, 3, 5};

    reset       = 1'b0;
    rwFromCpu   = C_IDEL;
    addrFromCpu = 8'h00;
    dataFromCpu = 8'h00;
    rdEnFromMem = 1'b0;
    wtEnFromMem = 1'b0;
    dataFromMem = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_rdEn", rdEn, 0);
    chk("rst_wtEn", wtEn, 0);
    chk("rst_dataToCpu", dataToCpu, 0);
    chk("rst_rwToMem", rwToMem, C_IDEL);
    chk("rst_addrToMem", addrToMem, 0);
    chk("rst_dataToMem", dataToMem, 0);
    chk("rst_hitCount", hitCount, 0);
    chk("rst_missCount", missCount, 0);
    chk("rst_state", ctrlState, 0);

    // Asynchronous reset while a fill is outstanding.
    rwFromCpu   = C_RD;
    addrFromCpu = 8'h05;
    @(negedge clk);
    chk("midfill_rwToMem", rwToMem, C_RD);
    chk("midfill_state", ctrlState, 1);
    chk("midfill_missCount", missCount, 1);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_rwToMem", rwToMem, C_IDEL);
    chk("async_rst_state", ctrlState, 0);
    chk("async_rst_missCount", missCount, 0);
    chk("async_rst_rdEn", rdEn, 0);
    rwFromCpu = C_IDEL;
    @(negedge clk);
    reset = 1'b1;
    $display("txn reset_mid_fill rwToMem=%0d state=%0d", rwToMem, ctrlState);

    for (int i = 0; i < 10; i++) run_txn(i, tbl[i]);

    // Unrecognised request code is ignored in IDLE.
    @(negedge clk);
    rwFromCpu   = 2'd3;
    addrFromCpu = 8'h05;
    repeat (3) @(negedge clk);
    chk("badcode_state", ctrlState, 0);
    chk("badcode_rwToMem", rwToMem, C_IDEL);
    chk("badcode_rdEn", rdEn | wtEn, 0);
    chk("badcode_hitCount", hitCount, 3);
    rwFromCpu = C_IDEL;
    $display("txn bad_code state=%0d rwToMem=%0d", ctrlState, rwToMem);

    // Miss with stray write-ack and CPU address change during FILL.
    @(negedge clk);
    rwFromCpu   = C_RD;
    addrFromCpu = 8'h0E;
    @(negedge clk);
    addrFromCpu = 8'h20;
    wtEnFromMem = 1'b1;
    @(negedge clk);
    wtEnFromMem = 1'b0;
    chk("stray_ack_state", ctrlState, 1);
    chk("stray_ack_wtEn", wtEn, 0);
    chk("fill_addr_held", addrToMem, 8'h0E);
    rdEnFromMem = 1'b1;
    dataFromMem = 8'h99;
    @(negedge clk);
    rdEnFromMem = 1'b0;
    chk("fill_rdEn", rdEn, 1);
    chk("fill_data", dataToCpu, 8'h99);
    chk("fill_missCount", missCount, 6);
    rwFromCpu = C_IDEL;
    @(negedge clk);
    $display("txn stray_ack_fill data=%02h misses=%0d", dataToCpu, missCount);

    // Hit counter saturation on repeated hits of 0x0E.
    for (int i = 0; i < 260; i++) begin
      t = '{C_RD, 8'h0E, 8'h00, 0, 8'h00, 0, 1, 0, 8'h99, (4 + i > 255) ? 255 : 4 + i, 6};
      run_txn(100 + i, t);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
